// File: rtl/seg_pkg.sv
// seg_pkg: shared types and constants for the 7-segment scan controller.
package seg_pkg;
    typedef enum logic {GAP, SHOW} state_t;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic AN_OFF = 1'b1;
    localparam int DP_BIT = 0;
endpackage

// File: rtl/seg_scan_ctrl_seghex.sv
// seghex: 4-bit hex to active-low a..g,dp segment decoder with blank input.
module seghex (
    input  logic [3:0] nib,
    input  logic       blank,
    output logic [7:0] seg
);
    localparam logic [7:0] LUT [16] = '{
        8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
        8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
    };
    assign seg = blank ? 8'hFF : LUT[nib];
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed 7-segment scanner with dead-time gaps and frame-synchronous updates.
// Define SEG_LZB_EN to enable leading-zero blanking on every transfer into the active set.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIGITS   = 8,
    parameter int SCAN_DIV = 50000,
    parameter int DEAD_CYC = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     blank_mask,
    input  logic [DIGITS-1:0]     dp_mask,
    output logic [DIGITS-1:0]     an,
    output logic [7:0]            seg,
    output logic                  frame_done
);
    localparam int CW = $clog2((SCAN_DIV > DEAD_CYC ? SCAN_DIV : DEAD_CYC) + 1);
    localparam int IW = $clog2(DIGITS);

    state_t state, state_n;
    logic [IW-1:0] idx, idx_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [4*DIGITS-1:0] act_val, pend_val, src_val, nval;
    logic [DIGITS-1:0] act_blank, act_dp, pend_blank, pend_dp, src_blank, src_dp, nblank, ndp, lzb;
    logic pend_valid, gap_end, show_end, boundary, xfer;
    logic [3:0] nib;
    logic [7:0] hex_seg, seg_n;
    logic [DIGITS-1:0] an_n;

    assign gap_end  = (DEAD_CYC == 0) || (cnt == CW'(DEAD_CYC - 1));
    assign show_end = cnt == CW'(SCAN_DIV - 1);
    assign boundary = (state == SHOW) && show_end && (idx == IW'(DIGITS - 1));
    assign frame_done = boundary;

    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt + 1'b1;
        if (state == GAP) begin
            if (gap_end) begin
                state_n = SHOW;
                cnt_n   = '0;
            end
        end else if (show_end) begin
            state_n = (DEAD_CYC == 0) ? SHOW : GAP;
            idx_n   = (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
            cnt_n   = '0;
        end
    end

    // A boundary load bypasses the pending set and lands straight in active.
    assign xfer      = boundary && (load || pend_valid);
    assign src_val   = load ? value : pend_val;
    assign src_blank = load ? blank_mask : pend_blank;
    assign src_dp    = load ? dp_mask : pend_dp;

`ifdef SEG_LZB_EN
    logic run;
    always_comb begin
        lzb = '0;
        run = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            run    = run && (src_val[4*i +: 4] == 4'h0);
            lzb[i] = run;
        end
    end
`else
    assign lzb = '0;
`endif

    assign nval   = xfer ? src_val : act_val;
    assign nblank = xfer ? (src_blank | lzb) : act_blank;
    assign ndp    = xfer ? src_dp : act_dp;
    assign nib    = nval[4*idx_n +: 4];

    seghex u_hex (
        .nib   (nib),
        .blank (nblank[idx_n]),
        .seg   (hex_seg)
    );

    // Outputs are computed from next-state values so they switch on the same edge as the state.
    always_comb begin
        an_n  = (state_n == SHOW) ? ~(DIGITS'(1) << idx_n) : {DIGITS{AN_OFF}};
        seg_n = (state_n == SHOW) ? hex_seg : SEG_BLANK;
        seg_n[DP_BIT] = seg_n[DP_BIT] & ~((state_n == SHOW) && ndp[idx_n]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= GAP;
            idx        <= '0;
            cnt        <= '0;
            act_val    <= '0;
            act_blank  <= '1;
            act_dp     <= '0;
            pend_val   <= '0;
            pend_blank <= '0;
            pend_dp    <= '0;
            pend_valid <= 1'b0;
            an         <= {DIGITS{AN_OFF}};
            seg        <= SEG_BLANK;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            cnt       <= cnt_n;
            act_val   <= nval;
            act_blank <= nblank;
            act_dp    <= ndp;
            if (load && !boundary) begin
                pend_val   <= value;
                pend_blank <= blank_mask;
                pend_dp    <= dp_mask;
                pend_valid <= 1'b1;
            end else if (boundary) begin
                pend_valid <= 1'b0;
            end
            an  <= an_n;
            seg <= seg_n;
        end
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: scoreboard bench for seg_scan_ctrl with DIGITS=4, SCAN_DIV=4, DEAD_CYC=2.
module tb_seg_scan_ctrl;
    logic clk = 1'b0, rst = 1'b1, load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0] blank_mask = '0, dp_mask = '0;
    logic [3:0] an;
    logic [7:0] seg;
    logic frame_done;
    logic [3:0] last_an = 4'hF;
    logic [11:0] sb[$];
    int passed = 0, total = 0;

    always #5 clk = ~clk;
    always @(posedge clk) last_an <= an;

    seg_scan_ctrl #(.DIGITS(4), .SCAN_DIV(4), .DEAD_CYC(2)) dut (
        .clk(clk), .rst(rst), .load(load), .value(value),
        .blank_mask(blank_mask), .dp_mask(dp_mask),
        .an(an), .seg(seg), .frame_done(frame_done)
    );

    task automatic wait_slot(output logic [3:0] a, output logic [7:0] s, output bit ok);
        ok = 0;
        a = 'x;
        s = 'x;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (an !== 4'hF && last_an === 4'hF) begin
                ok = 1;
                a = an;
                s = seg;
            end
        end
    endtask

    task automatic wait_fd(output bit ok);
        ok = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            ok = frame_done;
        end
    endtask

    task automatic push_frame(input logic [31:0] s);
        for (int i = 0; i < 4; i++) begin
            logic [3:0] m;
            m = ~(4'b0001 << i);
            sb.push_back({m, s[8*i +: 8]});
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] b, input logic [3:0] d);
        value = v;
        blank_mask = b;
        dp_mask = d;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic test_reset;
        bit ok;
        int n;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (an !== 4'hF || seg !== 8'hFF || frame_done !== 1'b0)
            $display("FAIL reset_state an=%b seg=%h fd=%b want 1111 ff 0", an, seg, frame_done);
        else passed++;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (an !== 4'hF || seg !== 8'hFF) $display("FAIL reset_gap an=%b seg=%h want 1111 ff", an, seg);
        else passed++;
        @(negedge clk);
        total++;
        if (an !== 4'b1110 || seg !== 8'hFF) $display("FAIL first_digit an=%b seg=%h want 1110 ff", an, seg);
        else passed++;
        wait_fd(ok);
        total++;
        if (!ok) $display("FAIL fd_timeout got none want pulse");
        else passed++;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 60);
        total++;
        if (n != 24) $display("FAIL frame_period got %0d want 24", n);
        else passed++;
    endtask

    task automatic test_load;
        bit ok;
        logic [3:0] a;
        logic [7:0] s;
        logic [11:0] e;
        wait_fd(ok);
        repeat (2) @(negedge clk);
        do_load(16'h12AF, 4'h0, 4'h0);
        push_frame({8'h9F, 8'h25, 8'h11, 8'h71});
        wait_slot(a, s, ok);
        total++;
        if (!ok || a !== 4'b1101 || s !== 8'hFF) $display("FAIL no_tear an=%b seg=%h want 1101 ff", a, s);
        else passed++;
        wait_fd(ok);
        for (int k = 0; k < 4; k++) begin
            wait_slot(a, s, ok);
            e = sb.pop_front();
            total++;
            if (!ok || {a, s} !== e) $display("FAIL load_12AF slot%0d an=%b seg=%h want an=%b seg=%h", k, a, s, e[11:8], e[7:0]);
            else passed++;
        end
    endtask

    task automatic test_back_to_back;
        bit ok;
        logic [3:0] a;
        logic [7:0] s;
        logic [11:0] e;
        wait_fd(ok);
        repeat (3) @(negedge clk);
        do_load(16'h1111, 4'h0, 4'h0);
        repeat (2) @(negedge clk);
        do_load(16'h2222, 4'h0, 4'h0);
        push_frame({4{8'h25}});
        wait_fd(ok);
        for (int k = 0; k < 4; k++) begin
            wait_slot(a, s, ok);
            e = sb.pop_front();
            total++;
            if (!ok || {a, s} !== e) $display("FAIL last_wins slot%0d an=%b seg=%h want an=%b seg=%h", k, a, s, e[11:8], e[7:0]);
            else passed++;
        end
        wait_fd(ok);
        do_load(16'h3333, 4'h0, 4'h0);
        push_frame({4{8'h0D}});
        for (int k = 0; k < 4; k++) begin
            wait_slot(a, s, ok);
            e = sb.pop_front();
            total++;
            if (!ok || {a, s} !== e) $display("FAIL boundary_load slot%0d an=%b seg=%h want an=%b seg=%h", k, a, s, e[11:8], e[7:0]);
            else passed++;
        end
    endtask

    task automatic test_lzb;
        bit ok;
        logic [3:0] a;
        logic [7:0] s;
        logic [11:0] e;
        wait_fd(ok);
        repeat (3) @(negedge clk);
        do_load(16'h0070, 4'h0, 4'h0);
`ifdef SEG_LZB_EN
        push_frame({8'hFF, 8'hFF, 8'h1F, 8'h03});
`else
        push_frame({8'h03, 8'h03, 8'h1F, 8'h03});
`endif
        wait_fd(ok);
        for (int k = 0; k < 4; k++) begin
            wait_slot(a, s, ok);
            e = sb.pop_front();
            total++;
            if (!ok || {a, s} !== e) $display("FAIL lzb_0070 slot%0d an=%b seg=%h want an=%b seg=%h", k, a, s, e[11:8], e[7:0]);
            else passed++;
        end
        do_load(16'h0000, 4'h0, 4'h0);
`ifdef SEG_LZB_EN
        push_frame({8'hFF, 8'hFF, 8'hFF, 8'h03});
`else
        push_frame({4{8'h03}});
`endif
        wait_fd(ok);
        for (int k = 0; k < 4; k++) begin
            wait_slot(a, s, ok);
            e = sb.pop_front();
            total++;
            if (!ok || {a, s} !== e) $display("FAIL lzb_0000 slot%0d an=%b seg=%h want an=%b seg=%h", k, a, s, e[11:8], e[7:0]);
            else passed++;
        end
    endtask

    task automatic test_dp_blank;
        bit ok;
        logic [3:0] a;
        logic [7:0] s;
        logic [11:0] e;
        wait_fd(ok);
        repeat (3) @(negedge clk);
        do_load(16'h5555, 4'b0001, 4'b0100);
        push_frame({8'h49, 8'h48, 8'h49, 8'hFF});
        wait_fd(ok);
        for (int k = 0; k < 4; k++) begin
            wait_slot(a, s, ok);
            e = sb.pop_front();
            total++;
            if (!ok || {a, s} !== e) $display("FAIL dp_blank slot%0d an=%b seg=%h want an=%b seg=%h", k, a, s, e[11:8], e[7:0]);
            else passed++;
        end
    endtask

    task automatic test_rst_mid;
        bit ok, found;
        logic [3:0] a;
        logic [7:0] s;
        logic [11:0] e;
        found = 0;
        for (int k = 0; k < 5 && !found; k++) begin
            wait_slot(a, s, ok);
            found = ok && (a == 4'b1011);
        end
        total++;
        if (!found) $display("FAIL find_digit2 an=%b want 1011", a);
        else passed++;
        do_load(16'h8888, 4'h0, 4'h0);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (an !== 4'hF || seg !== 8'hFF || frame_done !== 1'b0)
            $display("FAIL rst_mid an=%b seg=%h fd=%b want 1111 ff 0", an, seg, frame_done);
        else passed++;
        rst = 1'b0;
        push_frame({4{8'hFF}});
        push_frame({4{8'hFF}});
        for (int k = 0; k < 8; k++) begin
            wait_slot(a, s, ok);
            e = sb.pop_front();
            total++;
            if (!ok || {a, s} !== e) $display("FAIL rst_discard slot%0d an=%b seg=%h want an=%b seg=%h", k, a, s, e[11:8], e[7:0]);
            else passed++;
        end
    endtask

    initial begin
        test_reset;
        test_load;
        test_back_to_back;
        test_lzb;
        test_dp_blank;
        test_rst_mid;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for a bank of common-anode 7-segment digits. Holds a packed hex value, cycles one digit at a time through a single hex-to-segment decoder, and drives the active-low digit enables with a dead-time gap between digits to suppress ghosting. New values are double-buffered and applied only at frame boundaries, so a frame never tears. Sits between the numeric datapath and the board display pins.

## Interface
- DIGITS, 8: number of digits scanned (2..16)
- SCAN_DIV, 50000: clocks each digit is lit (>=2)
- DEAD_CYC, 16: clocks all digits are dark between digits (0 = no gap)

- clk  in  1  system clock, rising edge
- rst  in  1  reset; synchronous, active-high
- load  in  1  single-cycle strobe; captures value/blank_mask/dp_mask
- value  in  4*DIGITS  packed nibbles, digit 0 = bits [3:0] (rightmost)
- blank_mask  in  DIGITS  1 = force that digit dark
- dp_mask  in  DIGITS  1 = light decimal point of that digit
- an  out  DIGITS  digit enables, active-low, one-hot-low or all-high
- seg  out  8  segments a..g,dp in bits 7..0, active-low; 8'hFF = dark
- frame_done  out  1  one-cycle pulse when the last digit's SHOW ends

## Operation
- Registers: pending set (value/blank/dp + pend_valid), active set, digit index idx, cycle counter cnt, state.
- States: GAP (an all-high, seg 8'hFF) and SHOW (an[idx]=0, seg=decoded active nibble idx).
- GAP lasts DEAD_CYC cycles, then SHOW for idx; SHOW lasts SCAN_DIV cycles, then GAP with idx+1. DEAD_CYC=0: SHOW->SHOW directly with idx+1.
- Frame boundary = end of SHOW with idx=DIGITS-1: idx wraps to 0, frame_done=1 for that cycle, and if pend_valid, active <= pending, pend_valid <= 0.
- load when not at boundary: pending <= inputs, pend_valid <= 1; repeated loads overwrite (last wins).
- load on the boundary cycle: inputs go directly to active; pending untouched and pend_valid cleared.
- Decode: blank for digit i = active blank_mask[i] (OR lead-zero blank, see Configuration). Blank digit: seg=8'hFF but an[i] still driven low for its slot. dp_mask[i]=1 clears seg[0].
- Counter width clog2(max(SCAN_DIV,DEAD_CYC)+1); counts 0..N-1, clears on state change.

## Timing
- Reset values: an all ones, seg 8'hFF, frame_done 0, idx 0, cnt 0, state GAP, active set all zero with blank_mask all ones, pend_valid 0.
- an and seg are registered: they change on the same edge the state changes; no combinational path from inputs to outputs.
- First digit lit DEAD_CYC cycles after rst deasserts.
- Frame period = DIGITS*(SCAN_DIV+DEAD_CYC) cycles.
- Load-to-display latency: from 1 cycle (boundary load) to one full frame plus one cycle.
- rst mid-SHOW: next edge all outputs return to reset values; pending load discarded.

## Configuration
- SEG_LZB_EN defined: leading-zero blanking. On every transfer into active, digits from DIGITS-1 downward whose nibble is 0 are flagged blank until the first nonzero nibble; digit 0 is never lead-blanked. Flag ORed with blank_mask; dp_mask still applies to a lead-blanked digit.
- Undefined: only blank_mask blanks; zeros are displayed.

## Structure
- Package seg_pkg: state enum (GAP, SHOW), SEG_BLANK = 8'hFF, AN_OFF helper constant, dp bit index 0.
- One sub-module: seghex (existing 4-bit hex to active-low segment decoder with blank input), instantiated once on the selected nibble; controller registers its output and applies dp.

## Test plan
- DIGITS=4, SCAN_DIV=4, DEAD_CYC=2; reset then idle -> an=4'b1111, seg=8'hFF for 2 cycles, then an=4'b1110 with seg=8'hFF (all blank after reset); frame_done every 24 cycles.
- load value=16'h12AF, masks 0 mid-frame -> from next frame digits 0..3 show seg 8'h71, 8'h11, 8'h25, 8'h9F ('F','A','2','1'); an walks 1110,1101,1011,0111 with 2-cycle 1111 gaps.
- Two loads in one frame (16'h1111 then 16'h2222) -> next frame shows only 2222; load on frame_done cycle (16'h3333) -> digit 0 of the immediately following SHOW shows '3' (8'h0D).
- SEG_LZB_EN, load 16'h0070 -> digits 3,2 dark (8'hFF), digit 1 '7', digit 0 '0'; load 16'h0000 -> only digit 0 lit as '0' (8'h03). Without macro -> all four show '0'.
- dp_mask=4'b0100, blank_mask=4'b0001, value 16'h5555 -> digit 2 seg 8'h48, digit 0 8'hFF, others 8'h49.
- Assert rst during SHOW of digit 2 with pending load -> outputs at reset values next cycle; after release, display blank, pending not applied.
